// File: rtl/rv32i_types.sv
// Shared types and constants for the branch-predictor PHT port arbiter.
package rv32i_types;

  localparam int PHT_IDX_W     = 8;
  localparam int PHT_QDEPTH    = 4;
  localparam int PHT_MAX_DEFER = 3;

  // One pending counter update: which PHT slot and the new 2-bit value.
  typedef struct packed {
    logic [PHT_IDX_W-1:0] idx;
    logic [1:0]           ctr;
  } pht_upd_t;

endpackage

// File: rtl/pht_upd_fifo.sv
// Circular update queue. Entries are also presented in age order
// (index 0 = oldest) with per-slot valid bits so the arbiter can
// forward the newest matching update to a lookup.
module pht_upd_fifo
  import rv32i_types::*;
#(
  parameter int  QDEPTH = PHT_QDEPTH,
  localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  pht_upd_t                push_data,
  input  logic                    pop,
  output pht_upd_t                head,
  output logic [CNT_W-1:0]        count,
  output pht_upd_t [QDEPTH-1:0]   entries,
  output logic [QDEPTH-1:0]       valid
);

  pht_upd_t          mem [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_order
      assign entries[gi] = mem[rd_ptr_reg + PTR_W'(gi)];
      assign valid[gi]   = CNT_W'(gi) < count_reg;
    end
  endgenerate

endmodule

// File: rtl/pht_port_arbiter.sv
// Shares a single-port PHT between fetch lookups and queued EX updates.
// Lookups win the port unless the queue is full or its head has waited
// MAX_DEFER cycles; idle cycles drain the queue opportunistically.
module pht_port_arbiter
  import rv32i_types::*;
#(
  parameter int IDX_W     = PHT_IDX_W,
  parameter int QDEPTH    = PHT_QDEPTH,
  parameter int MAX_DEFER = PHT_MAX_DEFER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_req,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_grant,
  output logic             lk_valid,
  output logic [1:0]       lk_ctr,
  input  logic             upd_req,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [1:0]       upd_ctr,
  output logic             upd_ready,
  output logic             pht_we,
  output logic [IDX_W-1:0] pht_addr,
  output logic [1:0]       pht_wdata,
  input  logic [1:0]       pht_rdata
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int DEF_W = (MAX_DEFER < 1) ? 1 : $clog2(MAX_DEFER + 1);

  logic [CNT_W-1:0]      count;
  pht_upd_t              head;
  pht_upd_t              push_data;
  pht_upd_t [QDEPTH-1:0] entries;
  logic [QDEPTH-1:0]     entry_valid;

  logic [DEF_W-1:0]      defer_cnt_reg;
  logic                  lk_valid_reg;
  logic                  fwd_hit_reg;
  logic [1:0]            fwd_ctr_reg;
  logic                  fwd_hit_next;
  logic [1:0]            fwd_ctr_next;

  logic                  has_entries;
  logic                  force_drain;
  logic                  do_write;
  logic                  push;

  assign has_entries = (count != '0);
  assign force_drain = has_entries &&
                       ((count == CNT_W'(QDEPTH)) || (defer_cnt_reg == DEF_W'(MAX_DEFER)));
  // Reset suppresses all port activity so queued updates are discarded unwritten.
  assign do_write    = !rst && has_entries && (force_drain || !lk_req);
  assign lk_grant    = !rst && lk_req && !force_drain;
  assign upd_ready   = (count < CNT_W'(QDEPTH));
  assign push        = !rst && upd_req && upd_ready;

  assign push_data.idx = upd_idx;
  assign push_data.ctr = upd_ctr;

  assign pht_we    = do_write;
  assign pht_addr  = do_write ? head.idx : lk_idx;
  assign pht_wdata = do_write ? head.ctr : 2'b00;

  pht_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (do_write),
    .head      (head),
    .count     (count),
    .entries   (entries),
    .valid     (entry_valid)
  );

  // Newest matching update wins: scan oldest-to-newest, then the same-cycle enqueue.
  always_comb begin
    fwd_hit_next = 1'b0;
    fwd_ctr_next = 2'b00;
    for (int k = 0; k < QDEPTH; k++) begin
      if (entry_valid[k] && (entries[k].idx == lk_idx)) begin
        fwd_hit_next = 1'b1;
        fwd_ctr_next = entries[k].ctr;
      end
    end
    if (push && (upd_idx == lk_idx)) begin
      fwd_hit_next = 1'b1;
      fwd_ctr_next = upd_ctr;
    end
  end

  // Lookup response: valid one cycle after grant, with forwarding captured at grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_valid_reg <= 1'b0;
      fwd_hit_reg  <= 1'b0;
      fwd_ctr_reg  <= 2'b00;
    end else begin
      lk_valid_reg <= lk_grant;
      if (lk_grant) begin
        fwd_hit_reg <= fwd_hit_next;
        fwd_ctr_reg <= fwd_ctr_next;
      end
    end
  end

  // Starvation guard: count cycles the queue waits without a write, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      defer_cnt_reg <= '0;
    end else if (do_write || !has_entries) begin
      defer_cnt_reg <= '0;
    end else if (defer_cnt_reg != DEF_W'(MAX_DEFER)) begin
      defer_cnt_reg <= defer_cnt_reg + DEF_W'(1);
    end
  end

  assign lk_valid = lk_valid_reg;
  assign lk_ctr   = !lk_valid_reg ? 2'b01 : (fwd_hit_reg ? fwd_ctr_reg : pht_rdata);

endmodule

// File: tb/tb_pht_port_arbiter.sv
// Self-checking bench for pht_port_arbiter: directed scenarios followed by
// random traffic, all compared against a queue-based behavioural model.
module tb_pht_port_arbiter;

  localparam int QD = 4;
  localparam int MD = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       lk_req;
  logic [7:0] lk_idx;
  logic       lk_grant;
  logic       lk_valid;
  logic [1:0] lk_ctr;
  logic       upd_req;
  logic [7:0] upd_idx;
  logic [1:0] upd_ctr;
  logic       upd_ready;
  logic       pht_we;
  logic [7:0] pht_addr;
  logic [1:0] pht_wdata;
  logic [1:0] pht_rdata;

  pht_port_arbiter #(.IDX_W(8), .QDEPTH(QD), .MAX_DEFER(MD)) dut (
    .clk       (clk),
    .rst       (rst),
    .lk_req    (lk_req),
    .lk_idx    (lk_idx),
    .lk_grant  (lk_grant),
    .lk_valid  (lk_valid),
    .lk_ctr    (lk_ctr),
    .upd_req   (upd_req),
    .upd_idx   (upd_idx),
    .upd_ctr   (upd_ctr),
    .upd_ready (upd_ready),
    .pht_we    (pht_we),
    .pht_addr  (pht_addr),
    .pht_wdata (pht_wdata),
    .pht_rdata (pht_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural model: FIFO of pending updates, wait counter, pending response.
  typedef struct {
    int idx;
    int ctr;
  } upd_s;

  upd_s q[$];
  int   defer;
  bit   resp_pending;
  bit   resp_hit;
  int   resp_ctr;

  int   errors = 0;
  int   checks = 0;
  int   writes;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    defer        = 0;
    resp_pending = 0;
    resp_hit     = 0;
    resp_ctr     = 0;
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance model.
  task automatic step(input bit lr, input int li, input bit ur, input int ui,
                      input int uc, input int rd);
    int  n;
    bit  ready, forced, wr, gr, hit;
    int  ectr, fc;
    @(negedge clk);
    lk_req    = lr;
    lk_idx    = li[7:0];
    upd_req   = ur;
    upd_idx   = ui[7:0];
    upd_ctr   = uc[1:0];
    pht_rdata = rd[1:0];
    #1;
    n      = q.size();
    ready  = (n < QD);
    forced = (n > 0) && ((n == QD) || (defer == MD));
    wr     = (n > 0) && (forced || !lr);
    gr     = lr && !forced;
    ectr   = !resp_pending ? 1 : (resp_hit ? resp_ctr : rd);

    chk("upd_ready", 16'(upd_ready), 16'(ready));
    chk("lk_grant",  16'(lk_grant),  16'(gr));
    chk("pht_we",    16'(pht_we),    16'(wr));
    chk("lk_valid",  16'(lk_valid),  16'(resp_pending));
    chk("lk_ctr",    16'(lk_ctr),    16'(ectr));
    if (wr) begin
      chk("pht_addr_wr", 16'(pht_addr),  16'(q[0].idx));
      chk("pht_wdata",   16'(pht_wdata), 16'(q[0].ctr));
    end else begin
      chk("pht_addr_rd", 16'(pht_addr), 16'(li));
    end

    hit = 0;
    fc  = 0;
    if (gr) begin
      foreach (q[k]) if (q[k].idx == li) begin hit = 1; fc = q[k].ctr; end
      if (ur && ready && ui == li) begin hit = 1; fc = uc; end
    end
    resp_pending = gr;
    if (gr) begin resp_hit = hit; resp_ctr = fc; end

    if (wr) void'(q.pop_front());
    if (ur && ready) q.push_back('{idx: ui, ctr: uc});
    if (wr || n == 0) defer = 0;
    else if (defer < MD) defer = defer + 1;

    $display("t=%0t lk=%0b/%02h upd=%0b/%02h/%0d grant=%0b we=%0b addr=%02h wd=%0d valid=%0b ctr=%0d q=%0d",
             $time, lr, li[7:0], ur, ui[7:0], uc[1:0], lk_grant, pht_we, pht_addr,
             pht_wdata, lk_valid, lk_ctr, q.size());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    lk_req  = 1'b1;
    upd_req = 1'b1;
    #1;
    chk("rst_pht_we",   16'(pht_we),   16'(0));
    chk("rst_lk_grant", 16'(lk_grant), 16'(0));
    model_reset();
    $display("t=%0t reset", $time);
    @(negedge clk);
    rst = 1'b0;
    lk_req  = 1'b0;
    upd_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) step(0, 8'hFF, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; lk_req = 0; lk_idx = 0; upd_req = 0; upd_idx = 0; upd_ctr = 0; pht_rdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Reset state
    step(0, 0, 0, 0, 0, 0);
    chk("reset_upd_ready", 16'(upd_ready), 16'(1));
    chk("reset_lk_ctr",    16'(lk_ctr),    16'(2'b01));

    // Plain lookup
    step(1, 8'h12, 0, 0, 0, 0);
    chk("lookup_grant", 16'(lk_grant), 16'(1));
    step(0, 8'h12, 0, 0, 0, 3);
    chk("lookup_valid", 16'(lk_valid), 16'(1));
    chk("lookup_ctr",   16'(lk_ctr),   16'(2'b11));

    // Update drains on an idle port
    step(0, 0, 1, 8'h05, 2, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("idle_we",    16'(pht_we),    16'(1));
    chk("idle_addr",  16'(pht_addr),  16'(8'h05));
    chk("idle_wdata", 16'(pht_wdata), 16'(2'b10));
    step(0, 0, 0, 0, 0, 0);
    chk("idle_empty_we", 16'(pht_we), 16'(0));

    // Starvation guard under continuous lookups
    step(1, 8'h40, 1, 8'h33, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h40, 0, 0, 0, 2);
      chk("starve_grant", 16'(lk_grant), 16'(1));
    end
    step(1, 8'h40, 0, 0, 0, 2);
    chk("starve_we",    16'(pht_we),   16'(1));
    chk("starve_nogrant", 16'(lk_grant), 16'(0));
    step(1, 8'h40, 0, 0, 0, 2);
    chk("starve_resume", 16'(lk_grant), 16'(1));
    drain();

    // Full queue forces a write and rejects the extra update
    for (int i = 0; i < 4; i++) step(1, 8'h77, 1, 8'h60 + i, i, 0);
    step(1, 8'h77, 1, 8'h6F, 3, 0);
    chk("full_ready", 16'(upd_ready), 16'(0));
    chk("full_we",    16'(pht_we),    16'(1));
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 8'hFF, 0, 0, 0, 0);
      writes += int'(pht_we);
    end
    chk("full_drop_5th", 16'(writes), 16'(3));

    // Forwarding of the newest queued value
    step(1, 8'h99, 1, 8'h20, 0, 0);
    step(1, 8'h99, 1, 8'h20, 3, 0);
    step(1, 8'h20, 0, 0, 0, 0);
    chk("fwd_grant", 16'(lk_grant), 16'(1));
    step(0, 8'hFF, 0, 0, 0, 1);
    chk("fwd_ctr", 16'(lk_ctr), 16'(2'b11));
    drain();

    // Reset discards queued updates and cancels a pending response
    for (int i = 0; i < 3; i++) step(1, 8'h10, 1, 8'h50 + i, 1, 0);
    do_reset();
    step(0, 8'hFF, 0, 0, 0, 0);
    chk("rst_q_ready", 16'(upd_ready), 16'(1));
    chk("rst_q_valid", 16'(lk_valid),  16'(0));
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 8'hFF, 0, 0, 0, 0);
      writes += int'(pht_we);
    end
    chk("rst_no_writes", 16'(writes), 16'(0));

    // Random traffic over a small index set to provoke forwarding hits
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 65, $urandom_range(0, 7),
             $urandom_range(0, 99) < 55, $urandom_range(0, 7),
             $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pht_port_arbiter.md
PHT_PORT_ARBITER -- requirements
Module: pht_port_arbiter

Interface
REQ-001 SHALL have parameter IDX_W, default 8, PHT index width.
REQ-002 SHALL have parameter QDEPTH, default 4, update-queue entries (power of 2).
REQ-003 SHALL have parameter MAX_DEFER, default 3, max consecutive cycles a queued update waits before a forced drain.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-005 lk_req in 1: fetch-stage lookup request.
REQ-006 lk_idx in IDX_W: lookup index.
REQ-007 lk_grant out 1: lookup owns the PHT port this cycle.
REQ-008 lk_valid out 1: lookup result valid, one cycle after grant.
REQ-009 lk_ctr out 2: 2-bit counter result.
REQ-010 upd_req in 1: EX-stage counter update request.
REQ-011 upd_idx in IDX_W: update index.
REQ-012 upd_ctr in 2: new counter value.
REQ-013 upd_ready out 1: queue can accept an update.
REQ-014 pht_we out 1: PHT write enable.
REQ-015 pht_addr out IDX_W: PHT address.
REQ-016 pht_wdata out 2: PHT write data.
REQ-017 pht_rdata in 2: PHT read data, valid one cycle after read address.

Function
REQ-018 Single PHT port SHALL serve exactly one read or one write per cycle, never both.
REQ-019 upd_ready SHALL equal (count < QDEPTH), from registered count only; enqueue when upd_req & upd_ready; upd_req while not ready is dropped, and EX is responsible for holding it.
REQ-020 Port priority each cycle: (1) forced drain if queue non-empty and (count == QDEPTH or defer_cnt == MAX_DEFER) -> write head; (2) else lk_req -> read, lk_grant=1; (3) else queue non-empty -> write head; (4) else idle.
REQ-021 Head write: pht_we=1, pht_addr=head idx, pht_wdata=head ctr; head popped same cycle.
REQ-022 Read and idle cycles: pht_we=0, pht_addr=lk_idx.
REQ-023 lk_grant=0 whenever a write occurs, even with lk_req=1; fetch re-presents the request.
REQ-024 defer_cnt SHALL increment, saturating at MAX_DEFER, on each cycle the queue is non-empty and no write occurs; it clears on any write or when the queue is empty.
REQ-025 Enqueue and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo QDEPTH.
REQ-026 Forwarding: at grant, lk_idx is compared against all valid entries plus any same-cycle enqueue; the newest match's ctr is registered.
REQ-027 lk_valid SHALL be high exactly one cycle after lk_grant.
REQ-028 lk_ctr SHALL be the forwarded value on a hit, else pht_rdata.
REQ-029 lk_ctr SHALL be 2'b01 when lk_valid=0.

Reset
REQ-030 On rst: count, pointers and defer_cnt reset to 0; lk_valid=0; lk_grant=0; pht_we=0; upd_ready=1 from the next cycle.
REQ-031 rst mid-operation SHALL discard all queued updates without writing them, and SHALL cancel any pending lk_valid.

Structure
REQ-032 rv32i_types SHALL gain struct pht_upd_t {idx, ctr} and constants PHT_IDX_W=8, PHT_QDEPTH=4, PHT_MAX_DEFER=3.
REQ-033 The queue SHALL be sub-module pht_upd_fifo (pht_upd_t entries, exposing all valid entries for forwarding); arbitration, defer counter and response register stay in pht_port_arbiter.

Verification
REQ-034 Lookup only: lk_req=1, idx 0x12, pht_rdata=2'b11 -> lk_grant=1 in cycle 0; lk_valid=1, lk_ctr=2'b11 in cycle 1.
REQ-035 Idle port: update idx 0x05, ctr 2'b10 with no lk_req -> next cycle pht_we=1, addr 0x05, wdata 2'b10; count returns to 0.
REQ-036 Starvation: one queued update with lk_req held high -> 3 read grants, then in cycle 4 pht_we=1 and lk_grant=0, then reads resume.
REQ-037 Full queue: 4 updates enqueued under lk_req -> upd_ready=0 and the next cycle is a forced write; a 5th update offered while full is not enqueued.
REQ-038 Forwarding: queue idx 0x20 ctr 2'b00, then 2'b11, with pht_rdata=2'b01 -> lookup of 0x20 returns lk_ctr=2'b11.
REQ-039 Reset with 3 entries queued -> no further pht_we, upd_ready=1, lk_valid=0.
